// File: rtl/fifo_multi_ported.sv
// Multi-ported FIFO: NPUSH push lanes compacted into FIFO order, NPOP pop
// lanes presented as a window starting at the head, prefix pop semantics.
module fifo_multi_ported #(
  parameter int DW    = 16,
  parameter int DEPTH = 8,
  parameter int NPUSH = 2,
  parameter int NPOP  = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [NPUSH-1:0]               push,
  input  logic [NPUSH*DW-1:0]            push_data,
  output logic [NPUSH-1:0]               ready,
  output logic [NPOP*DW-1:0]             pop_data,
  output logic [NPOP-1:0]                valid,
  input  logic [NPOP-1:0]                pop,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty,
  output logic                           pop_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0]  head;
  logic [AW-1:0]  tail;
  logic [DW-1:0]  mem [DEPTH];

  logic [NPUSH-1:0] accept;
  logic [AW-1:0]    waddr [NPUSH];
  int unsigned      n_push;
  logic [NPOP-1:0]  eff;
  int unsigned      n_pop;
  logic             err_next;

  // Pointer advance modulo DEPTH; the offset never exceeds DEPTH, so a single
  // conditional subtract wraps correctly for any depth.
  function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] base,
                                              input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= 32'(DEPTH)) sum = sum - 32'(DEPTH);
    return AW'(sum);
  endfunction

  // Lane readiness and validity come from registered occupancy only.
  always_comb begin
    for (int i = 0; i < NPUSH; i++)
      ready[i] = (32'(DEPTH) - 32'(count)) > 32'(i);
    for (int j = 0; j < NPOP; j++)
      valid[j] = 32'(count) > 32'(j);
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Compact accepted push lanes onto consecutive slots starting at tail.
  // NOTE: every always_comb output gets a value before any conditional code,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    n_push = 0;
    accept = '0;
    for (int i = 0; i < NPUSH; i++) begin
      accept[i] = push[i] & ready[i];
      waddr[i]  = wrap_add(tail, n_push);
      if (accept[i]) n_push = n_push + 1;
    end
  end

  // Pops are effective only as an unbroken prefix of valid, requested lanes.
  always_comb begin
    logic chain;
    chain = 1'b1;
    n_pop = 0;
    eff   = '0;
    for (int j = 0; j < NPOP; j++) begin
      eff[j] = chain & pop[j] & valid[j];
      chain  = eff[j];
      if (eff[j]) n_pop = n_pop + 1;
    end
    err_next = |(pop & ~eff);
  end

  // Read window: lane j shows the entry j places behind the head.
  always_comb begin
    pop_data = '0;
    for (int j = 0; j < NPOP; j++)
      pop_data[j*DW +: DW] = mem[wrap_add(head, j)];
  end

  // Storage write for accepted lanes.
  // NOTE: the data array has no reset; valid/count already mask stale
  // entries, and leaving it reset-free lets it map onto plain storage.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      for (int i = 0; i < NPUSH; i++)
        if (accept[i]) mem[waddr[i]] <= push_data[i*DW +: DW];
    end
  end

  // Pointer, occupancy and error-pulse state; flush wins over traffic.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      pop_err <= 1'b0;
    end else begin
      pop_err <= err_next;
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        tail  <= wrap_add(tail, n_push);
        head  <= wrap_add(head, n_pop);
        count <= CW'(32'(count) + n_push - n_pop);
      end
    end
  end

endmodule

// File: tb/tb_fifo_multi_ported.sv
// Self-checking bench for fifo_multi_ported: default config (a), a three-lane
// push config (b) and a depth-5 config (c), checked against queue models.
module tb_fifo_multi_ported;

  logic clk;
  logic rst;

  // instance a: defaults
  logic        a_flush;
  logic [1:0]  a_push, a_ready, a_valid, a_pop;
  logic [31:0] a_pdata, a_pop_data;
  logic [3:0]  a_count;
  logic        a_full, a_empty, a_pop_err;

  // instance b: three push lanes
  logic        b_flush;
  logic [2:0]  b_push, b_ready;
  logic [47:0] b_pdata;
  logic [31:0] b_pop_data;
  logic [1:0]  b_valid, b_pop;
  logic [3:0]  b_count;
  logic        b_full, b_empty, b_pop_err;

  // instance c: depth 5
  logic        c_flush;
  logic [1:0]  c_push, c_ready, c_valid, c_pop;
  logic [31:0] c_pdata, c_pop_data;
  logic [2:0]  c_count;
  logic        c_full, c_empty, c_pop_err;

  int n_cmp;
  int n_err;
  logic [15:0] sb_a[$];
  logic [15:0] sb_c[$];

  fifo_multi_ported u_a (
    .clk(clk), .rst(rst), .flush(a_flush), .push(a_push), .push_data(a_pdata),
    .ready(a_ready), .pop_data(a_pop_data), .valid(a_valid), .pop(a_pop),
    .count(a_count), .full(a_full), .empty(a_empty), .pop_err(a_pop_err));

  fifo_multi_ported #(.DW(16), .DEPTH(8), .NPUSH(3), .NPOP(2)) u_b (
    .clk(clk), .rst(rst), .flush(b_flush), .push(b_push), .push_data(b_pdata),
    .ready(b_ready), .pop_data(b_pop_data), .valid(b_valid), .pop(b_pop),
    .count(b_count), .full(b_full), .empty(b_empty), .pop_err(b_pop_err));

  fifo_multi_ported #(.DW(16), .DEPTH(5), .NPUSH(2), .NPOP(2)) u_c (
    .clk(clk), .rst(rst), .flush(c_flush), .push(c_push), .push_data(c_pdata),
    .ready(c_ready), .pop_data(c_pop_data), .valid(c_valid), .pop(c_pop),
    .count(c_count), .full(c_full), .empty(c_empty), .pop_err(c_pop_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t reached, expected finish well before", $time);
    $fatal(1, "bench timeout");
  end

  // One clock of traffic on instance a (which==0) or c (which==1): checks the
  // pre-edge outputs against the queue model, drives the lanes, then checks
  // the error pulse and updates the model.
  task automatic run_cycle(input int which, input logic [1:0] pu,
                           input logic [15:0] d0, input logic [15:0] d1,
                           input logic [1:0] po, input logic fl);
    logic [15:0] q[$];
    int          depth, sz, obs_count;
    logic [1:0]  exp_ready, exp_valid, obs_ready, obs_valid, eff;
    logic        chain, exp_err, obs_full, obs_empty, obs_err;
    logic [31:0] obs_pd;
    string       nm;
    if (which == 0) begin
      q = sb_a; depth = 8; nm = "fifo_a";
      obs_ready = a_ready; obs_valid = a_valid; obs_count = int'(a_count);
      obs_full = a_full; obs_empty = a_empty; obs_pd = a_pop_data;
    end else begin
      q = sb_c; depth = 5; nm = "fifo_c";
      obs_ready = c_ready; obs_valid = c_valid; obs_count = int'(c_count);
      obs_full = c_full; obs_empty = c_empty; obs_pd = c_pop_data;
    end
    sz = q.size();
    for (int i = 0; i < 2; i++) begin
      exp_ready[i] = (depth - sz) > i;
      exp_valid[i] = sz > i;
    end
    n_cmp++;
    if (obs_count !== sz) begin
      n_err++; $display("FAIL %s count: got %0d expected %0d", nm, obs_count, sz);
    end
    n_cmp++;
    if (obs_ready !== exp_ready) begin
      n_err++; $display("FAIL %s ready: got %b expected %b", nm, obs_ready, exp_ready);
    end
    n_cmp++;
    if (obs_valid !== exp_valid) begin
      n_err++; $display("FAIL %s valid: got %b expected %b", nm, obs_valid, exp_valid);
    end
    n_cmp++;
    if (obs_full !== (sz == depth) || obs_empty !== (sz == 0)) begin
      n_err++;
      $display("FAIL %s full/empty: got %b/%b expected %b/%b", nm, obs_full, obs_empty,
               sz == depth, sz == 0);
    end
    for (int j = 0; j < 2; j++) begin
      if (exp_valid[j]) begin
        n_cmp++;
        if (obs_pd[j*16 +: 16] !== q[j]) begin
          n_err++;
          $display("FAIL %s pop_data[%0d]: got %h expected %h", nm, j, obs_pd[j*16 +: 16], q[j]);
        end
      end
    end
    chain = 1'b1;
    for (int j = 0; j < 2; j++) begin
      eff[j] = chain & po[j] & exp_valid[j];
      chain  = eff[j];
    end
    exp_err = |(po & ~eff);
    if (which == 0) begin
      a_push = pu; a_pdata = {d1, d0}; a_pop = po; a_flush = fl;
    end else begin
      c_push = pu; c_pdata = {d1, d0}; c_pop = po; c_flush = fl;
    end
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else begin
      for (int j = 0; j < 2; j++) if (eff[j]) void'(q.pop_front());
      if (pu[0] & exp_ready[0]) q.push_back(d0);
      if (pu[1] & exp_ready[1]) q.push_back(d1);
    end
    obs_err = (which == 0) ? a_pop_err : c_pop_err;
    n_cmp++;
    if (obs_err !== exp_err) begin
      n_err++; $display("FAIL %s pop_err: got %b expected %b", nm, obs_err, exp_err);
    end
    if (which == 0) begin
      a_push = '0; a_pop = '0; a_flush = 1'b0; sb_a = q;
    end else begin
      c_push = '0; c_pop = '0; c_flush = 1'b0; sb_c = q;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_cmp++;
    if (a_count !== 4'd0 || a_valid !== 2'b00 || a_empty !== 1'b1 || a_full !== 1'b0) begin
      n_err++;
      $display("FAIL reset_a_state: got count=%0d valid=%b empty=%b full=%b expected 0/00/1/0",
               a_count, a_valid, a_empty, a_full);
    end
    n_cmp++;
    if (a_ready !== 2'b11 || a_pop_err !== 1'b0) begin
      n_err++; $display("FAIL reset_a_ready: got ready=%b pop_err=%b expected 11/0", a_ready, a_pop_err);
    end
    n_cmp++;
    if (b_ready !== 3'b111 || b_empty !== 1'b1) begin
      n_err++; $display("FAIL reset_b: got ready=%b empty=%b expected 111/1", b_ready, b_empty);
    end
    n_cmp++;
    if (c_ready !== 2'b11 || c_count !== 3'd0) begin
      n_err++; $display("FAIL reset_c: got ready=%b count=%0d expected 11/0", c_ready, c_count);
    end
    // traffic while reset is held must be discarded
    a_push = 2'b11; a_pdata = 32'h1234_5678; a_pop = 2'b01;
    @(posedge clk);
    #1;
    n_cmp++;
    if (a_count !== 4'd0 || a_pop_err !== 1'b0) begin
      n_err++; $display("FAIL reset_discard: got count=%0d pop_err=%b expected 0/0", a_count, a_pop_err);
    end
    a_push = '0; a_pop = '0;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_cycle(0, 2'b11, 16'hAAAA, 16'hBBBB, 2'b00, 1'b0);
    n_cmp++;
    if (a_count !== 4'd2 || a_valid !== 2'b11) begin
      n_err++; $display("FAIL basic_occupancy: got count=%0d valid=%b expected 2/11", a_count, a_valid);
    end
    n_cmp++;
    if (a_pop_data !== 32'hBBBB_AAAA) begin
      n_err++; $display("FAIL basic_data: got %h expected bbbbaaaa", a_pop_data);
    end
    run_cycle(0, 2'b00, 16'h0, 16'h0, 2'b11, 1'b0);
    run_cycle(0, 2'b00, 16'h0, 16'h0, 2'b00, 1'b0);
  endtask

  task automatic test_illegal_pop();
    run_cycle(0, 2'b01, 16'h1111, 16'h0, 2'b00, 1'b0);
    run_cycle(0, 2'b00, 16'h0, 16'h0, 2'b10, 1'b0);
    n_cmp++;
    if (a_count !== 4'd1 || a_pop_err !== 1'b1) begin
      n_err++; $display("FAIL illegal_lane1: got count=%0d pop_err=%b expected 1/1", a_count, a_pop_err);
    end
    run_cycle(0, 2'b00, 16'h0, 16'h0, 2'b00, 1'b0);
    run_cycle(0, 2'b00, 16'h0, 16'h0, 2'b11, 1'b0);
    n_cmp++;
    if (a_count !== 4'd0 || a_pop_err !== 1'b1) begin
      n_err++; $display("FAIL illegal_overpop: got count=%0d pop_err=%b expected 0/1", a_count, a_pop_err);
    end
    run_cycle(0, 2'b00, 16'h0, 16'h0, 2'b00, 1'b0);
  endtask

  task automatic test_flush();
    run_cycle(0, 2'b11, 16'hF001, 16'hF002, 2'b00, 1'b0);
    run_cycle(0, 2'b11, 16'hF003, 16'hF004, 2'b00, 1'b0);
    run_cycle(0, 2'b11, 16'hF005, 16'hF006, 2'b11, 1'b1);
    n_cmp++;
    if (a_count !== 4'd0 || a_empty !== 1'b1 || a_ready !== 2'b11) begin
      n_err++;
      $display("FAIL flush_state: got count=%0d empty=%b ready=%b expected 0/1/11", a_count, a_empty, a_ready);
    end
    run_cycle(0, 2'b00, 16'h0, 16'h0, 2'b01, 1'b1);
    run_cycle(0, 2'b11, 16'hF007, 16'hF008, 2'b00, 1'b0);
    run_cycle(0, 2'b00, 16'h0, 16'h0, 2'b11, 1'b0);
  endtask

  task automatic test_compaction();
    logic [15:0] q[$];
    b_push = 3'b101; b_pdata = {16'h2222, 16'hDEAD, 16'h1111};
    q.push_back(16'h1111); q.push_back(16'h2222);
    n_cmp++;
    if (b_valid !== 2'b00) begin
      n_err++; $display("FAIL compact_no_bypass: got valid=%b expected 00", b_valid);
    end
    @(posedge clk); #1; b_push = '0;
    n_cmp++;
    if (b_count !== 4'd2 || b_pop_data !== 32'h2222_1111) begin
      n_err++; $display("FAIL compact_gap: got count=%0d data=%h expected 2/22221111", b_count, b_pop_data);
    end
    b_push = 3'b110; b_pdata = {16'h3302, 16'h3301, 16'hDEAD};
    q.push_back(16'h3301); q.push_back(16'h3302);
    @(posedge clk); #1; b_push = '0;
    n_cmp++;
    if (b_count !== 4'd4 || b_ready !== 3'b111) begin
      n_err++; $display("FAIL compact_upper: got count=%0d ready=%b expected 4/111", b_count, b_ready);
    end
    b_push = 3'b111; b_pdata = {16'h4403, 16'h4402, 16'h4401};
    q.push_back(16'h4401); q.push_back(16'h4402); q.push_back(16'h4403);
    @(posedge clk); #1; b_push = '0;
    n_cmp++;
    if (b_count !== 4'd7 || b_ready !== 3'b001) begin
      n_err++; $display("FAIL compact_partial_ready: got count=%0d ready=%b expected 7/001", b_count, b_ready);
    end
    b_push = 3'b111; b_pdata = {16'h5503, 16'h5502, 16'h5501};
    q.push_back(16'h5501);
    @(posedge clk); #1; b_push = '0;
    n_cmp++;
    if (b_count !== 4'd8 || b_full !== 1'b1 || b_ready !== 3'b000) begin
      n_err++;
      $display("FAIL compact_full: got count=%0d full=%b ready=%b expected 8/1/000", b_count, b_full, b_ready);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (b_pop_data !== {q[1], q[0]}) begin
        n_err++; $display("FAIL compact_order[%0d]: got %h expected %h", k, b_pop_data, {q[1], q[0]});
      end
      b_pop = 2'b11;
      @(posedge clk); #1; b_pop = '0;
      void'(q.pop_front()); void'(q.pop_front());
    end
    n_cmp++;
    if (b_empty !== 1'b1 || b_pop_err !== 1'b0) begin
      n_err++; $display("FAIL compact_drain: got empty=%b pop_err=%b expected 1/0", b_empty, b_pop_err);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] d;
    d = 16'hC000;
    run_cycle(1, 2'b11, d, d + 16'd1, 2'b00, 1'b0); d = d + 16'd2;
    run_cycle(1, 2'b11, d, d + 16'd1, 2'b00, 1'b0); d = d + 16'd2;
    run_cycle(1, 2'b11, d, d + 16'd1, 2'b00, 1'b0); d = d + 16'd2;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) run_cycle(1, 2'b11, d, d + 16'd1, 2'b11, 1'b0);
      else            run_cycle(1, 2'b11, d, d + 16'd1, 2'b00, 1'b0);
      d = d + 16'd2;
    end
    run_cycle(1, 2'b00, 16'h0, 16'h0, 2'b11, 1'b0);
    run_cycle(1, 2'b00, 16'h0, 16'h0, 2'b11, 1'b0);
    run_cycle(1, 2'b00, 16'h0, 16'h0, 2'b01, 1'b0);
    run_cycle(1, 2'b00, 16'h0, 16'h0, 2'b00, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++)
      run_cycle(0, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
                2'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0));
    run_cycle(0, 2'b00, 16'h0, 16'h0, 2'b00, 1'b1);
  endtask

  task automatic test_async_reset();
    run_cycle(0, 2'b11, 16'hE001, 16'hE002, 2'b00, 1'b0);
    run_cycle(0, 2'b11, 16'hE003, 16'hE004, 2'b00, 1'b0);
    run_cycle(0, 2'b11, 16'hE005, 16'hE006, 2'b00, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (a_count !== 4'd0 || a_valid !== 2'b00 || a_empty !== 1'b1 || a_ready !== 2'b11) begin
      n_err++;
      $display("FAIL async_reset: got count=%0d valid=%b empty=%b ready=%b expected 0/00/1/11",
               a_count, a_valid, a_empty, a_ready);
    end
    a_push = 2'b11; a_pdata = 32'h5555_6666;
    @(posedge clk); #1;
    n_cmp++;
    if (a_count !== 4'd0) begin
      n_err++; $display("FAIL async_reset_hold: got count=%0d expected 0", a_count);
    end
    a_push = '0;
    rst = 1'b0;
    sb_a.delete();
    sb_c.delete();
    run_cycle(0, 2'b11, 16'h7001, 16'h7002, 2'b00, 1'b0);
    run_cycle(0, 2'b00, 16'h0, 16'h0, 2'b11, 1'b0);
    run_cycle(0, 2'b00, 16'h0, 16'h0, 2'b00, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    a_flush = 1'b0; a_push = '0; a_pdata = '0; a_pop = '0;
    b_flush = 1'b0; b_push = '0; b_pdata = '0; b_pop = '0;
    c_flush = 1'b0; c_push = '0; c_pdata = '0; c_pop = '0;
    test_reset();
    test_basic();
    test_illegal_pop();
    test_flush();
    test_compaction();
    test_wrap();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_multi_ported.md
FIFO_MULTI_PORTED -- requirements
Module: fifo_multi_ported

Interface
REQ-001 SHALL have parameter DW, default 16, data bits per entry.
REQ-002 SHALL have parameter DEPTH, default 8, entries; any integer >= max(NPUSH,NPOP) and >= 2; power of two not required.
REQ-003 SHALL have parameter NPUSH, default 2, push lanes (>= 1).
REQ-004 SHALL have parameter NPOP, default 2, pop lanes (>= 1).
REQ-005 SHALL have port clk  input  1  clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port flush  input  1  synchronous empty request.
REQ-008 SHALL have port push  input  NPUSH  per-lane push request.
REQ-009 SHALL have port push_data  input  NPUSH x DW  per-lane write data.
REQ-010 SHALL have port ready  output  NPUSH  per-lane push acceptance.
REQ-011 SHALL have port pop_data  output  NPOP x DW  lane j = entry head+j.
REQ-012 SHALL have port valid  output  NPOP  lane j holds data.
REQ-013 SHALL have port pop  input  NPOP  per-lane pop request.
REQ-014 SHALL have port count  output  clog2(DEPTH+1)  current occupancy.
REQ-015 SHALL have port full, empty  output  1 each  count==DEPTH / count==0.
REQ-016 SHALL have port pop_err  output  1  registered illegal-pop pulse.

Function
REQ-017 SHALL define free = DEPTH - count; ready[i] = (free > i), from registered state only.
REQ-018 SHALL define valid[j] = (count > j), from registered state only.
REQ-019 SHALL accept push lane i iff push[i] & ready[i]; non-accepted requests are dropped, state unchanged for that lane.
REQ-020 SHALL compact accepted pushes: lane i written at tail + (number of accepted lanes below i), mod DEPTH; lane order = FIFO order; gaps allowed (e.g. lanes 0 and 2 only -> tail, tail+1).
REQ-021 SHALL treat pops as a prefix: pop lane j effective iff pop[j] & valid[j] & all lanes below j effective.
REQ-022 SHALL flag pop_err high next cycle (one cycle) when any pop[j] is asserted but not effective; ineffective pops do not change state.
REQ-023 SHALL present pop_data[j] combinationally from memory[(head+j) mod DEPTH]; pop_data undefined-but-stable where valid[j]=0.
REQ-024 SHALL update per cycle: tail += P, head += Q (mod DEPTH, explicit wrap, no power-of-two masking), count += P - Q, where P = accepted pushes, Q = effective pops.
REQ-025 SHALL make pushed data visible on valid/pop_data the cycle after acceptance (1-cycle latency); no same-cycle bypass.
REQ-026 SHALL not use same-cycle pops to raise ready; a full FIFO with pop asserted accepts no push that cycle.
REQ-027 SHALL, on flush, set head=tail=count=0 next edge; flush overrides simultaneous push/pop (no write counted, pop_err still computed).
REQ-028 SHALL hold state when P=Q=0; count never exceeds DEPTH nor goes below 0.
REQ-029 SHALL not reset or clear memory contents (data regs reset-free).

Reset
REQ-030 SHALL on rst assert drive head=tail=0, count=0, pop_err=0, immediately and asynchronously, regardless of clk.
REQ-031 SHALL give reset-state outputs: valid=0, empty=1, full=0, ready all 1 (DEPTH >= NPUSH), count=0.
REQ-032 SHALL discard any push/pop in the cycle rst is asserted; operation resumes on the first edge after deassert.

Verification
REQ-033 Defaults, reset, push lanes 0,1 with A,B -> next cycle count=2, valid=11, pop_data={B,A}.
REQ-034 Compaction: NPUSH=3, push=101 data X,_,Z on empty -> count=2, pop_data[0]=X, pop_data[1]=Z.
REQ-035 Wrap: DEPTH=5, fill 5, pop 2, push 2, repeat 10 cycles -> order preserved, full=1 at count 5, ready=00 when full.
REQ-036 Illegal pop: count=1, pop=10 (lane1 only) -> no state change, pop_err=1 for one cycle; pop=11 at count=1 -> Q=1, pop_err=1.
REQ-037 Flush vs traffic: count=4, flush with push=11, pop=11 -> next cycle count=0, empty=1, ready=11.
REQ-038 Async reset mid-operation: count=6, assert rst between edges -> count=0, valid=0 immediately, before next clk edge.
